// File: rtl/psum_fifo_pkg.sv
// psum_fifo_pkg: shared defaults, channel index type and grant cleanup helper
// for the partial-sum FIFO bank.
// Optional error flags are built when PSUM_FIFO_ERR_EN is defined.
package psum_fifo_pkg;

   localparam int unsigned DEF_NUM_CH = 3;
   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_DEPTH  = 8;
   localparam int unsigned DEF_CH_W   = $clog2(DEF_NUM_CH);

   // Widest grant vector the helper below handles.
   localparam int unsigned MAX_CH = 32;

   typedef logic [DEF_CH_W-1:0] ch_idx_t;

   // Keep only the lowest set bit of a (possibly multi-hot) vector.
   function automatic logic [MAX_CH-1:0] onehot_lowest(input logic [MAX_CH-1:0] v);
      return v & (~v + MAX_CH'(1));
   endfunction

endpackage

// File: rtl/psum_fifo_bank_if.sv
// psum_fifo_bank_if: push/pop/output bus of the partial-sum FIFO bank.
//   master: array columns + arbiter side (drives wr_en, wr_data, gnt)
//   slave : the FIFO bank (drives full, req, out_*, and err_* with PSUM_FIFO_ERR_EN)
interface psum_fifo_bank_if
   import psum_fifo_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   localparam int unsigned CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]        wr_en;
   logic [NUM_CH*DATA_W-1:0] wr_data;
   logic [NUM_CH-1:0]        full;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        gnt;
   logic                     out_valid;
   logic [CH_W-1:0]          out_ch;
   logic [DATA_W-1:0]        out_data;
`ifdef PSUM_FIFO_ERR_EN
   logic [NUM_CH-1:0]        err_ovf;
   logic [NUM_CH-1:0]        err_udf;

   modport master (output wr_en, wr_data, gnt,
                   input  full, req, out_valid, out_ch, out_data, err_ovf, err_udf);
   modport slave  (input  wr_en, wr_data, gnt,
                   output full, req, out_valid, out_ch, out_data, err_ovf, err_udf);
`else
   modport master (output wr_en, wr_data, gnt,
                   input  full, req, out_valid, out_ch, out_data);
   modport slave  (input  wr_en, wr_data, gnt,
                   output full, req, out_valid, out_ch, out_data);
`endif

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: one channel of the bank -- storage, pointers, occupancy count.
//   push/push_data : write strobe and word (dropped when full)
//   pop            : read strobe (ignored when empty)
//   head_c         : word at the read pointer
//   full_c         : count == DEPTH
//   nonempty_c     : count != 0
//   pop_drop/err_* : ignored-grant event in, sticky flags out (PSUM_FIFO_ERR_EN)
module sync_fifo
   import psum_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_c,
   output logic              full_c,
   output logic              nonempty_c
`ifdef PSUM_FIFO_ERR_EN
  ,input  logic              pop_drop,
   output logic              err_ovf,
   output logic              err_udf
`endif
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   // A push while full is dropped even if this cycle also pops.
   assign full_c     = (count == CNT_W'(DEPTH));
   assign nonempty_c = (count != '0);
   assign do_push    = push && !full_c;
   assign do_pop     = pop && nonempty_c;
   assign head_c     = mem[rd_ptr];

   // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   // Storage is not reset; reset empties the FIFO through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

`ifdef PSUM_FIFO_ERR_EN
   // Sticky misuse flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (push && full_c) err_ovf <= 1'b1;
         if (pop_drop)       err_udf <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/psum_fifo_bank.sv
// psum_fifo_bank: NUM_CH partial-sum FIFOs feeding a round-robin writeback
// arbiter, with one registered, channel-tagged output port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : psum_fifo_bank_if.slave (wr_en/wr_data/gnt in; full/req/out_* out)
// Defining PSUM_FIFO_ERR_EN adds sticky err_ovf/err_udf flags.
module psum_fifo_bank
   import psum_fifo_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input logic             clk,
   input logic             rst,
   psum_fifo_bank_if.slave bus
);
   localparam int unsigned CH_W = $clog2(NUM_CH);

   logic [DATA_W-1:0] head [NUM_CH];
   logic [NUM_CH-1:0] full_vec;
   logic [NUM_CH-1:0] req_vec;
   logic [NUM_CH-1:0] pop_sel;
   logic [CH_W-1:0]   sel_ch;
   logic [DATA_W-1:0] sel_data;
   logic              out_valid_q;
   logic [CH_W-1:0]   out_ch_q;
   logic [DATA_W-1:0] out_data_q;

   // Grants on empty channels are ignored; of the rest, the lowest index wins.
   assign pop_sel = NUM_CH'(onehot_lowest(MAX_CH'(bus.gnt & req_vec)));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push       (bus.wr_en[i]),
         .push_data  (bus.wr_data[i*DATA_W +: DATA_W]),
         .pop        (pop_sel[i]),
         .head_c     (head[i]),
         .full_c     (full_vec[i]),
         .nonempty_c (req_vec[i])
`ifdef PSUM_FIFO_ERR_EN
        ,.pop_drop   (bus.gnt[i] && !pop_sel[i]),
         .err_ovf    (bus.err_ovf[i]),
         .err_udf    (bus.err_udf[i])
`endif
      );
   end

   // Select the popped channel's head word.
   always_comb begin
      sel_ch   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pop_sel[i]) begin
            sel_ch   = CH_W'(i);
            sel_data = head[i];
         end
      end
   end

   // Output register; channel/data hold when nothing pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= |pop_sel;
         if (|pop_sel) begin
            out_ch_q   <= sel_ch;
            out_data_q <= sel_data;
         end
      end
   end

   assign bus.full      = full_vec;
   assign bus.req       = req_vec;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_psum_fifo_bank.sv
// tb_psum_fifo_bank: directed, self-checking bench for psum_fifo_bank.
// Per-channel model queues predict every pop; predicted words go to a
// scoreboard and are compared when out_valid appears.
module tb_psum_fifo_bank;
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [15:0] mq [NUM_CH][$];
   logic [17:0] sb [$];
   logic [1:0]  last_ch;
   logic [15:0] last_data;
   int          rr_last;
`ifdef PSUM_FIFO_ERR_EN
   logic [2:0]  m_ovf;
   logic [2:0]  m_udf;
`endif

   psum_fifo_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   psum_fifo_bank #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      sb.delete();
      last_ch   = '0;
      last_data = '0;
      rr_last   = NUM_CH - 1;
`ifdef PSUM_FIFO_ERR_EN
      m_ovf = '0;
      m_udf = '0;
`endif
   endtask

   // Compare all visible outputs against the model after an edge.
   task automatic check_out(input logic exp_valid);
      logic [17:0] e;
      logic [2:0]  exp_req;
      logic [2:0]  exp_full;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=1 expected=0");
         end else begin
            e = sb.pop_front();
            chk("out_ch", 32'(bus.out_ch), 32'(e[17:16]));
            chk("out_data", 32'(bus.out_data), 32'(e[15:0]));
            last_ch   = e[17:16];
            last_data = e[15:0];
         end
      end else begin
         chk("out_ch_hold", 32'(bus.out_ch), 32'(last_ch));
         chk("out_data_hold", 32'(bus.out_data), 32'(last_data));
      end
      for (int i = 0; i < NUM_CH; i++) begin
         exp_req[i]  = (mq[i].size() != 0);
         exp_full[i] = (mq[i].size() == DEPTH);
      end
      chk("req", 32'(bus.req), 32'(exp_req));
      chk("full", 32'(bus.full), 32'(exp_full));
`ifdef PSUM_FIFO_ERR_EN
      chk("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
      chk("err_udf", 32'(bus.err_udf), 32'(m_udf));
`endif
   endtask

   // One clock: drive inputs, predict, clock, check at edge+1.
   task automatic step(input logic [2:0] we, input logic [47:0] wd, input logic [2:0] g);
      int          sel;
      logic [2:0]  pre_full;
      logic [2:0]  sel_vec;
      logic [15:0] w;
      sel     = -1;
      sel_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pre_full[i] = (mq[i].size() == DEPTH);
         if (sel < 0 && g[i] && mq[i].size() != 0) sel = i;
      end
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.gnt     = g;
      @(posedge clk);
      if (sel >= 0) begin
         w = mq[sel].pop_front();
         sb.push_back({2'(sel), w});
         sel_vec[sel] = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++)
         if (we[i] && !pre_full[i]) mq[i].push_back(wd[i*16 +: 16]);
`ifdef PSUM_FIFO_ERR_EN
      m_ovf = m_ovf | (we & pre_full);
      m_udf = m_udf | (g & ~sel_vec);
`endif
      #1;
      bus.wr_en   = '0;
      bus.wr_data = '0;
      bus.gnt     = '0;
      check_out(sel >= 0);
   endtask

   task automatic push1(input int ch, input logic [15:0] d, input logic [2:0] g);
      logic [47:0] wd;
      wd = '0;
      wd[ch*16 +: 16] = d;
      step(3'(1 << ch), wd, g);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(3'b000, 48'h0, 3'b000);
   endtask

   // Round-robin grant from the model state, starting after the last winner.
   task automatic rr_step();
      logic [2:0] g;
      int c;
      g = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (rr_last + k) % NUM_CH;
         if (g == '0 && mq[c].size() != 0) begin
            g = 3'(1 << c);
            rr_last = c;
         end
      end
      step(3'b000, 48'h0, g);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.wr_en   = '0;
      bus.wr_data = '0;
      bus.gnt     = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out(1'b0);
      idle(5);

      // Three pushes to ch0 then three single-channel pops.
      push1(0, 16'h0011, 3'b000);
      push1(0, 16'h0022, 3'b000);
      push1(0, 16'h0033, 3'b000);
      step(3'b000, 48'h0, 3'b001);
      step(3'b000, 48'h0, 3'b001);
      step(3'b000, 48'h0, 3'b001);
      idle(2);

      // Async reset mid-burst clears outputs without a clock edge.
      push1(0, 16'h0044, 3'b000);
      push1(0, 16'h0055, 3'b000);
      step(3'b000, 48'h0, 3'b001);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("async_rst_req", 32'(bus.req), 32'h0);
      chk("async_rst_out_data", 32'(bus.out_data), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_out(1'b0);

      // Fill ch1, overflow push, drain; repeat to exercise pointer wrap.
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < DEPTH; k++) push1(1, 16'(16'h1100 + pass * 16'h100 + k), 3'b000);
         push1(1, 16'hDEAD, 3'b000);
         push1(1, 16'hBEEF, 3'b010);
         for (int k = 0; k < DEPTH - 1; k++) step(3'b000, 48'h0, 3'b010);
         idle(1);
      end

      // Two words in every channel, drained by a round-robin arbiter.
      step(3'b111, {16'h2001, 16'h1001, 16'h0001}, 3'b000);
      step(3'b111, {16'h2002, 16'h1002, 16'h0002}, 3'b000);
      rr_last = NUM_CH - 1;
      for (int k = 0; k < 6; k++) rr_step();
      idle(1);

      // Same-cycle push+pop on ch2 holding four words keeps order and count.
      for (int k = 0; k < 4; k++) push1(2, 16'(16'h3000 + k), 3'b000);
      push1(2, 16'h3004, 3'b100);
      push1(2, 16'h3005, 3'b100);
      for (int k = 0; k < 4; k++) step(3'b000, 48'h0, 3'b100);
      idle(1);
      // Push with grant to an empty channel: no fall-through.
      push1(2, 16'h3abc, 3'b100);
      step(3'b000, 48'h0, 3'b100);
      idle(1);

      // Multi-hot grant pops only the lowest requesting channel.
      push1(0, 16'h4000, 3'b000);
      push1(1, 16'h4111, 3'b000);
      step(3'b000, 48'h0, 3'b011);
      step(3'b000, 48'h0, 3'b100);
      step(3'b000, 48'h0, 3'b010);
      idle(1);

      // Random mixed traffic against the model.
      for (int k = 0; k < 60; k++)
         step(3'($urandom_range(0, 7)),
              {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535))},
              3'($urandom_range(0, 7)));
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_fifo_bank.md
# psum_fifo_bank

Bank of NUM_CH independent synchronous FIFOs buffering per-column partial-sum results from the systolic array ahead of the round-robin writeback arbiter. Each FIFO's not-empty flag drives the arbiter's request vector, and the arbiter's one-hot grant acts as the read enable. The popped word is presented on a single registered output port, tagged with its channel index, for the writeback path.

## Interface
- NUM_CH, 3, number of channels (≥2); matches arbiter width
- DATA_W, 16, word width
- DEPTH, 8, entries per FIFO; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  NUM_CH  per-channel push strobe from array columns
- wr_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- full  out  NUM_CH  channel i holds DEPTH entries
- req  out  NUM_CH  channel i non-empty (to arbiter req)
- gnt  in  NUM_CH  one-hot pop from arbiter (rd_en)
- out_valid  out  1  out_data/out_ch valid this cycle
- out_ch  out  $clog2(NUM_CH)  source channel of out_data
- out_data  out  DATA_W  popped word
- err_ovf  out  NUM_CH  sticky push-while-full, PSUM_FIFO_ERR_EN only
- err_udf  out  NUM_CH  sticky pop-while-empty or multi-hot gnt, PSUM_FIFO_ERR_EN only

## Operation
- Per channel: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH)+1 bits).
- Push: wr_en[i] && !full[i] writes wr_data slice at wr_ptr, wr_ptr++.
- Push while full is dropped, even with a same-cycle pop on that channel; storage and pointers are unchanged.
- Pop: gnt[i] && req[i] reads entry at rd_ptr, rd_ptr++.
- gnt[i] with req[i]=0 is ignored.
- Multi-hot gnt: only the lowest-indexed set bit with req=1 pops; the rest are ignored.
- Simultaneous push and pop on a non-full, non-empty channel: count unchanged, both pointers advance.
- Push to an empty channel with a same-cycle gnt: no pop; there is no fall-through.
- full[i] = (count==DEPTH); req[i] = (count!=0); both derived from registered count.
- Output register:
  - Cycle after a pop: out_valid=1, out_ch=channel, out_data=popped word.
  - Otherwise out_valid=0; out_ch/out_data hold their last value.

## Timing
- Reset values: pointers/counts 0, full=0, req=0, out_valid=0, out_ch=0, out_data=0, err_*=0.
- Assertion of rst clears everything immediately (async), including mid-burst; stored data is discarded.
- Push latency: word pushed at edge N sets req at N, so it is visible to the arbiter in cycle N+1.
- Pop-to-output latency: 1 cycle. gnt sampled at edge N gives out_valid high after edge N.
- Back-to-back pops of one channel at full rate: DEPTH pops drain a full FIFO in DEPTH cycles; req falls after the last pop edge.
- full deasserts the cycle after a pop from a full FIFO; a push in that pop cycle is still dropped.

## Configuration
- PSUM_FIFO_ERR_EN defined:
  - err_ovf[i] set on wr_en[i] && full[i].
  - err_udf[i] set on gnt[i] && !req[i], or on gnt[i] ignored due to multi-hot.
  - Both flags are sticky until rst.
- Undefined: err_ovf/err_udf ports and their logic are absent; data-path behaviour is identical.

## Structure
- Package psum_fifo_pkg holds:
  - default NUM_CH/DATA_W/DEPTH localparams
  - typedef ch_idx_t ($clog2(NUM_CH) bits)
  - function onehot_lowest for grant cleanup
- Sub-module sync_fifo (one channel: storage, pointers, count, full/empty; optional ovf/udf) instantiated NUM_CH times via generate.
- Output mux/register lives in the top.

## Test plan
- Reset, then idle: req=000, full=000, out_valid=0 for 5 cycles; async rst mid-cycle clears out_valid without a clock edge.
- Push 0x0011, 0x0022, 0x0033 to ch0, pulse gnt=001 three times -> out_data 0x0011, 0x0022, 0x0033 with out_ch=0 one cycle after each gnt; req[0] falls after third pop.
- Fill ch1 with 8 words -> full[1]=1; push 0xDEAD while full -> dropped (err_ovf[1]=1 with macro); drain returns the original 8 in order, with pointer wrap verified by a second fill/drain.
- All channels loaded with 2 words each, gnt driven by rr_arbiter with gnt_en=1 -> out_ch sequence 0,1,2,0,1,2, then req=000.
- Same-cycle push+pop on ch2 with count=4 -> count stays 4, FIFO order preserved; push+gnt on empty ch2 -> no out_valid that cycle, req[2]=1 next.
- gnt=011 with ch0 and ch1 non-empty -> only ch0 pops (err_udf[1]=1 with macro); gnt=100 on empty ch2 -> no pop, out_valid=0.
